// File: rtl/complex_alu_pipe_pkg.sv
// Shared definitions for the complex ALU pipeline: opcodes, default widths,
// and the accumulator width rule.
package complex_alu_pipe_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS_DEF  = 15;
  localparam int ACC_GUARD_DEF  = 8;

  typedef enum logic [2:0] {
    OP_PASS    = 3'b000,
    OP_ACC     = 3'b011,
    OP_MUL     = 3'b100,
    OP_MULADD  = 3'b101,
    OP_MULCONJ = 3'b110,
    OP_MAX     = 3'b111
  } op_e;

  // The two unassigned encodings (001, 010) collapse onto PASS.
  function automatic op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'b011:  return OP_ACC;
      3'b100:  return OP_MUL;
      3'b101:  return OP_MULADD;
      3'b110:  return OP_MULCONJ;
      3'b111:  return OP_MAX;
      default: return OP_PASS;
    endcase
  endfunction

  function automatic int acc_width(input int data_width, input int acc_guard);
    return 2 * data_width + 1 + acc_guard;
  endfunction

endpackage

// File: rtl/cplx_round_sat.sv
// One-component round-half-up, arithmetic shift by FRAC_BITS and saturation
// to OUT_W signed bits; sat_o flags a clipped result.
module cplx_round_sat #(
  parameter int IN_W      = 41,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic        [OUT_W-1:0] val_o,
  output logic                    sat_o
);

  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] HALF =
    $signed({{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1));
  localparam logic signed [SUM_W-1:0] MAX_V =
    $signed({{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] MIN_V =
    $signed({{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  // One extra MSB so the rounding increment can never wrap a full-scale input.
  assign sum     = $signed({val_i[IN_W-1], val_i}) + HALF;
  assign shifted = sum >>> FRAC_BITS;

  always_comb begin
    val_o = shifted[OUT_W-1:0];
    sat_o = 1'b0;
    if (shifted > MAX_V) begin
      val_o = MAX_V[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (shifted < MIN_V) begin
      val_o = MIN_V[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/complex_alu_pipe.sv
// Four-stage flow-controlled complex ALU: MUL, MULADD, MULCONJ, MAX, PASS and
// a multi-beat complex accumulate, with round-half-up and saturation.
module complex_alu_pipe
  import complex_alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int ACC_GUARD  = ACC_GUARD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              opcode,
  input  logic                    in_last,
  input  logic [2*DATA_WIDTH-1:0] din_1,
  input  logic [2*DATA_WIDTH-1:0] din_2,
  input  logic [2*DATA_WIDTH-1:0] din_3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] dout,
  output logic                    sat
);

  localparam int W2        = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ACC_GUARD);
  localparam int EXT       = ACC_WIDTH - W2;
  localparam int CEXT      = ACC_WIDTH - DATA_WIDTH;

  // Handshake: a beat moves on a cycle with in_valid && in_ready, a result is
  // consumed on a cycle with out_valid && out_ready. The whole pipe advances
  // together (en) whenever the output register is empty or being consumed.
  logic en;
  logic out_valid_q;
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // S1: operand capture
  logic          s1_valid_q, s1_last_q;
  op_e           s1_op_q;
  logic [W2-1:0] s1_a_q, s1_b_q, s1_c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_op_q    <= OP_PASS;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_last;
      s1_op_q    <= decode_op(opcode);
      s1_a_q     <= din_1;
      s1_b_q     <= din_2;
      s1_c_q     <= din_3;
    end
  end

  // S2: partial products and squared magnitudes
  logic signed [W2-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [W2-1:0] sq_ar, sq_ai, sq_br, sq_bi;
  logic signed [W2-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic        [W2:0]   mag_a_d, mag_b_d;

  assign ar_x = $signed({{DATA_WIDTH{s1_a_q[W2-1]}}, s1_a_q[W2-1:DATA_WIDTH]});
  assign ai_x = $signed({{DATA_WIDTH{s1_a_q[DATA_WIDTH-1]}}, s1_a_q[DATA_WIDTH-1:0]});
  assign br_x = $signed({{DATA_WIDTH{s1_b_q[W2-1]}}, s1_b_q[W2-1:DATA_WIDTH]});
  assign bi_x = $signed({{DATA_WIDTH{s1_b_q[DATA_WIDTH-1]}}, s1_b_q[DATA_WIDTH-1:0]});

  assign p_rr_d  = ar_x * br_x;
  assign p_ii_d  = ai_x * bi_x;
  assign p_ri_d  = ar_x * bi_x;
  assign p_ir_d  = ai_x * br_x;
  assign sq_ar   = ar_x * ar_x;
  assign sq_ai   = ai_x * ai_x;
  assign sq_br   = br_x * br_x;
  assign sq_bi   = bi_x * bi_x;
  // Squares are non-negative; the extra bit holds (-2^(N-1))^2 + (-2^(N-1))^2.
  assign mag_a_d = {1'b0, sq_ar} + {1'b0, sq_ai};
  assign mag_b_d = {1'b0, sq_br} + {1'b0, sq_bi};

  logic                 s2_valid_q, s2_last_q;
  op_e                  s2_op_q;
  logic signed [W2-1:0] s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;
  logic        [W2:0]   s2_mag_a_q, s2_mag_b_q;
  logic        [W2-1:0] s2_a_q, s2_b_q, s2_c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_op_q    <= OP_PASS;
      s2_rr_q    <= '0;
      s2_ii_q    <= '0;
      s2_ri_q    <= '0;
      s2_ir_q    <= '0;
      s2_mag_a_q <= '0;
      s2_mag_b_q <= '0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_c_q     <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_op_q    <= s1_op_q;
      s2_rr_q    <= p_rr_d;
      s2_ii_q    <= p_ii_d;
      s2_ri_q    <= p_ri_d;
      s2_ir_q    <= p_ir_d;
      s2_mag_a_q <= mag_a_d;
      s2_mag_b_q <= mag_b_d;
      s2_a_q     <= s1_a_q;
      s2_b_q     <= s1_b_q;
      s2_c_q     <= s1_c_q;
    end
  end

  // S3: combine into ACC_WIDTH-wide components
  logic signed [ACC_WIDTH-1:0] rr_x, ii_x, ri_x, ir_x, cr_x, ci_x;
  logic signed [ACC_WIDTH-1:0] mul_re, mul_im;
  logic signed [ACC_WIDTH-1:0] acc_re_q, acc_im_q, acc_base_re, acc_base_im;
  logic signed [ACC_WIDTH-1:0] s3_re_d, s3_im_d;
  logic        [W2-1:0]        raw_sel;
  logic                        s3_raw_d, s3_emit_d;
  logic                        acc_first_q;

  assign rr_x = $signed({{EXT{s2_rr_q[W2-1]}}, s2_rr_q});
  assign ii_x = $signed({{EXT{s2_ii_q[W2-1]}}, s2_ii_q});
  assign ri_x = $signed({{EXT{s2_ri_q[W2-1]}}, s2_ri_q});
  assign ir_x = $signed({{EXT{s2_ir_q[W2-1]}}, s2_ir_q});
  assign cr_x = $signed({{CEXT{s2_c_q[W2-1]}}, s2_c_q[W2-1:DATA_WIDTH]}) <<< FRAC_BITS;
  assign ci_x = $signed({{CEXT{s2_c_q[DATA_WIDTH-1]}}, s2_c_q[DATA_WIDTH-1:0]}) <<< FRAC_BITS;

  assign mul_re      = rr_x - ii_x;
  assign mul_im      = ri_x + ir_x;
  assign acc_base_re = acc_first_q ? '0 : acc_re_q;
  assign acc_base_im = acc_first_q ? '0 : acc_im_q;
  // Non-final ACC beats only update the accumulator; they never reach S4.
  assign s3_emit_d   = s2_valid_q && (s2_op_q != OP_ACC || s2_last_q);

  always_comb begin
    s3_re_d  = mul_re;
    s3_im_d  = mul_im;
    s3_raw_d = 1'b0;
    raw_sel  = s2_a_q;
    case (s2_op_q)
      OP_MUL: ;
      OP_MULADD: begin
        s3_re_d = mul_re + cr_x;
        s3_im_d = mul_im + ci_x;
      end
      OP_MULCONJ: begin
        s3_re_d = rr_x + ii_x + cr_x;
        s3_im_d = ir_x - ri_x + ci_x;
      end
      OP_ACC: begin
        s3_re_d = acc_base_re + mul_re;
        s3_im_d = acc_base_im + mul_im;
      end
      OP_MAX: begin
        s3_raw_d = 1'b1;
        raw_sel  = (s2_mag_a_q >= s2_mag_b_q) ? s2_a_q : s2_b_q;
      end
      default: s3_raw_d = 1'b1;
    endcase
    if (s3_raw_d) begin
      s3_re_d = $signed({{CEXT{raw_sel[W2-1]}}, raw_sel[W2-1:DATA_WIDTH]});
      s3_im_d = $signed({{CEXT{raw_sel[DATA_WIDTH-1]}}, raw_sel[DATA_WIDTH-1:0]});
    end
  end

  logic                        s3_valid_q, s3_raw_q;
  logic signed [ACC_WIDTH-1:0] s3_re_q, s3_im_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q  <= 1'b0;
      s3_raw_q    <= 1'b0;
      s3_re_q     <= '0;
      s3_im_q     <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      acc_first_q <= 1'b1;
    end else if (en) begin
      s3_valid_q <= s3_emit_d;
      s3_raw_q   <= s3_raw_d;
      s3_re_q    <= s3_re_d;
      s3_im_q    <= s3_im_d;
      if (s2_valid_q && s2_op_q == OP_ACC) begin
        acc_re_q    <= s3_re_d;
        acc_im_q    <= s3_im_d;
        acc_first_q <= s2_last_q;
      end
    end
  end

  // S4: round/saturate and output register
  logic [DATA_WIDTH-1:0] rnd_re, rnd_im;
  logic                  sat_re, sat_im;
  logic [W2-1:0]         dout_d, dout_q;
  logic                  sat_d, sat_q;

  cplx_round_sat #(.IN_W(ACC_WIDTH), .OUT_W(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_rs_re (
    .val_i (s3_re_q),
    .val_o (rnd_re),
    .sat_o (sat_re)
  );

  cplx_round_sat #(.IN_W(ACC_WIDTH), .OUT_W(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_rs_im (
    .val_i (s3_im_q),
    .val_o (rnd_im),
    .sat_o (sat_im)
  );

  assign dout_d = s3_raw_q ? {s3_re_q[DATA_WIDTH-1:0], s3_im_q[DATA_WIDTH-1:0]}
                           : {rnd_re, rnd_im};
  assign sat_d  = !s3_raw_q && (sat_re || sat_im);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_complex_alu_pipe.sv
// Randomised and directed bench for complex_alu_pipe against a longint
// arithmetic reference model with an in-order expected queue.
module tb_complex_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [2:0]  opcode;
  logic [31:0] din_1, din_2, din_3, dout;
  logic        out_valid, out_ready, sat;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  longint      m_acc_re = 0;
  longint      m_acc_im = 0;
  bit          m_first  = 1'b1;
  bit          fired;

  always #5 clk = ~clk;

  complex_alu_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .in_last   (in_last),
    .din_1     (din_1),
    .din_2     (din_2),
    .din_3     (din_3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sat       (sat)
  );

  // ---------------- reference model ----------------
  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint wrap41(input longint x);
    return (x <<< 23) >>> 23;
  endfunction

  function automatic logic [16:0] rsat(input longint x);
    longint y;
    y = (x + 64'sd16384) >>> 15;
    if (y > 32767)  return {1'b1, 16'h7fff};
    if (y < -32768) return {1'b1, 16'h8000};
    return {1'b0, y[15:0]};
  endfunction

  function automatic void model_accept(input logic [2:0] op, input logic last,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    longint ar, ai, br, bi, cr, ci, re, im, ma, mb;
    logic [16:0] rs, is;
    bit emit, raw;
    logic [31:0] rawv;
    ar = sx16(a[31:16]); ai = sx16(a[15:0]);
    br = sx16(b[31:16]); bi = sx16(b[15:0]);
    cr = sx16(c[31:16]) * 32768; ci = sx16(c[15:0]) * 32768;
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    emit = 1'b1; raw = 1'b0; rawv = a;
    case (op)
      3'b100: ;
      3'b101: begin re = re + cr; im = im + ci; end
      3'b110: begin re = ar * br + ai * bi + cr; im = ai * br - ar * bi + ci; end
      3'b011: begin
        m_acc_re = wrap41((m_first ? 64'sd0 : m_acc_re) + re);
        m_acc_im = wrap41((m_first ? 64'sd0 : m_acc_im) + im);
        m_first  = last;
        re = m_acc_re; im = m_acc_im;
        emit = last;
      end
      3'b111: begin
        ma = ar * ar + ai * ai;
        mb = br * br + bi * bi;
        raw = 1'b1;
        rawv = (ma >= mb) ? a : b;
      end
      default: raw = 1'b1;
    endcase
    if (emit) begin
      if (raw) exp_q.push_back({1'b0, rawv});
      else begin
        rs = rsat(re);
        is = rsat(im);
        exp_q.push_back({rs[16] | is[16], rs[15:0], is[15:0]});
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h80008000;
      1:       return 32'h7fff7fff;
      2:       return {16'h8000, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- clock/driver tasks ----------------
  task automatic tick();
    #1;
    fired = in_valid && in_ready;
    if (out_valid && out_ready) obs_q.push_back({sat, dout});
    if (fired) model_accept(opcode, in_last, din_1, din_2, din_3);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [2:0] op, input logic last,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
    opcode = op; in_last = last; din_1 = a; din_2 = b; din_3 = c;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (fired) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100 && obs_q.size() < exp_q.size(); k++) tick();
    for (int k = 0; k < 6; k++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; opcode = 3'b000;
    din_1 = '0; din_2 = '0; din_3 = '0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 00000000", dout); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    logic [32:0] o, e;
    out_ready = 1'b1;
    opcode = 3'b100; in_last = 1'b0; din_1 = 32'h40004000; din_2 = 32'h4000c000; din_3 = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: edge %0d got out_valid %b expected 0", k, out_valid); end
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_4: got out_valid %b expected 1", out_valid); end
    checks++; if ({sat, dout} !== 33'h040000000) begin errors++; $display("FAIL latency_value: got %h expected 040000000", {sat, dout}); end
    drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL latency_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL latency_model: got %h expected %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_directed();
    logic [2:0]  ops [8] = '{3'b100, 3'b100, 3'b101, 3'b110, 3'b111, 3'b111, 3'b001, 3'b010};
    logic [31:0] va  [8] = '{32'h40004000, 32'h80000000, 32'h40000000, 32'h00004000,
                             32'h10000000, 32'h40000000, 32'h12345678, 32'h8000ffff};
    logic [31:0] vb  [8] = '{32'h4000c000, 32'h80000000, 32'h40000000, 32'h00004000,
                             32'h00002000, 32'h00004000, 32'hdeadbeef, 32'h11111111};
    logic [31:0] vc  [8] = '{32'h0, 32'h0, 32'h20001000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [32:0] ref_v [8] = '{33'h040000000, 33'h17fff0000, 33'h040001000, 33'h020000000,
                               33'h000002000, 33'h040000000, 33'h012345678, 33'h08000ffff};
    logic [32:0] o, e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive_beat(ops[i], 1'b0, va[i], vb[i], vc[i]);
    drain();
    checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL directed_count: got %0d expected 8", obs_q.size()); end
    for (int i = 0; i < 8 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL directed_model[%0d]: got %h expected %h", i, o, e); end
      checks++; if (o !== ref_v[i]) begin errors++; $display("FAIL directed_const[%0d]: got %h expected %h", i, o, ref_v[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_acc();
    logic [32:0] o, e;
    out_ready = 1'b1;
    drive_beat(3'b011, 1'b0, 32'h20000000, 32'h40000000, 32'h0);
    drive_beat(3'b011, 1'b0, 32'h20000000, 32'h40000000, 32'h0);
    drive_beat(3'b100, 1'b1, 32'h7fff1234, 32'h40004000, 32'h0);
    drive_beat(3'b011, 1'b0, 32'h20000000, 32'h40000000, 32'h0);
    drive_beat(3'b011, 1'b1, 32'h20000000, 32'h40000000, 32'h0);
    drain();
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL acc_count: got %0d expected 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[1] !== 33'h040000000) begin errors++; $display("FAIL acc_total: got %h expected 040000000", obs_q[1]); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL acc_model: got %h expected %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] ba [8];
    logic [31:0] bb [8];
    logic [33:0] prev_out;
    logic [32:0] o, e;
    bit prev_stall;
    int sent;
    for (int i = 0; i < 8; i++) begin ba[i] = rand_op(); bb[i] = rand_op(); end
    sent = 0; prev_stall = 1'b0; prev_out = '0;
    opcode = 3'b100; in_last = 1'b0; din_3 = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (sent == 8 && obs_q.size() >= exp_q.size()) break;
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      if (sent < 8) begin din_1 = ba[sent]; din_2 = bb[sent]; end
      #1;
      checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", cyc, in_ready, !out_valid || out_ready); end
      if (prev_stall) begin
        checks++; if ({out_valid, sat, dout} !== prev_out) begin errors++; $display("FAIL bp_stable: cycle %0d got %h expected %h", cyc, {out_valid, sat, dout}, prev_out); end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, sat, dout};
      tick();
      if (fired) sent++;
    end
    in_valid = 1'b0;
    drain();
    checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bp_order: got %h expected %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [32:0] o, e;
    logic [2:0]  op;
    logic        last;
    logic [31:0] a, b, c;
    int          n_exp;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      last = ($urandom_range(0, 2) == 0);
      if (i == 79) begin op = 3'b011; last = 1'b1; end
      a = rand_op(); b = rand_op(); c = rand_op();
      opcode = op; in_last = last; din_1 = a; din_2 = b; din_3 = c;
      for (int k = 0; k < 200; k++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        if (fired) break;
      end
      in_valid = 1'b0;
    end
    drain();
    n_exp = exp_q.size();
    checks++; if (obs_q.size() !== n_exp) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), n_exp); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rand_model: got %h expected %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_acc();
    logic [32:0] o, e;
    out_ready = 1'b1;
    drive_beat(3'b011, 1'b0, 32'h7fff7fff, 32'h7fff7fff, 32'h0);
    drive_beat(3'b011, 1'b0, 32'h40001000, 32'h20003000, 32'h0);
    drive_beat(3'b100, 1'b0, 32'h40004000, 32'h40004000, 32'h0);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    exp_q.delete(); obs_q.delete();
    m_first = 1'b1; m_acc_re = 0; m_acc_im = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b expected 0", out_valid); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_hold_dout: got %h expected 00000000", dout); end
    rst = 1'b0;
    tick();
    drive_beat(3'b011, 1'b1, 32'h40000000, 32'h40000000, 32'h0);
    drive_beat(3'b111, 1'b0, 32'h10000000, 32'h00002000, 32'h0);
    drain();
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL rst_acc_count: got %0d expected 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0] !== 33'h020000000) begin errors++; $display("FAIL rst_acc_fresh: got %h expected 020000000", obs_q[0]); end
      checks++; if (obs_q[1] !== 33'h000002000) begin errors++; $display("FAIL rst_max: got %h expected 000002000", obs_q[1]); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rst_model: got %h expected %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_acc();
    test_backpressure();
    test_random();
    test_reset_mid_acc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
